top_channel_transmitter: RTL

- Sending end of the 2-bit top-function channel consumed by the per-permutator top receivers.
- Accepts one 128-bit top function per handshake and serializes it one bit per cycle as {valid, data}, LSB first.
- Appends an even-parity beat and enforces an idle gap so the receiver can resynchronize.
- Sits in the host/control clock domain and drives the fabric-wide topChannel fanout, which is registered further downstream.

---
 rtl/top_channel_transmitter_if.sv | 11 +
 rtl/top_channel_transmitter.sv | 94 +++++++++
 2 files changed

// File: rtl/top_channel_transmitter_if.sv
// Top-function handoff from the requester to the channel transmitter.
// Handshake: a transfer happens on a rising clk edge where topValid and topReady are both high;
// top is sampled only on that edge, and topValid held while topReady is low is simply ignored.
interface top_channel_transmitter_if;
  logic [127:0] top;
  logic         topValid;
  logic         topReady;

  modport master (output top, output topValid, input topReady);
  modport slave  (input top, input topValid, output topReady);
endinterface

// File: rtl/top_channel_transmitter.sv
// Serializes one 128-bit top function per handshake onto the 2-bit {valid, data} channel,
// LSB first, followed by an even-parity beat and a forced idle gap.
module top_channel_transmitter #(
  parameter int GAP_CYCLES  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  top_channel_transmitter_if.slave topIf,
  output logic [1:0]             topChannel,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] framesSent,
  output logic [1:0]             stateDbg
);

  typedef enum logic [1:0] {IDLE, SEND, PARITY, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t       state;
  state_t       stateNext;
  logic [127:0] shiftReg;
  logic         parityBit;
  logic [6:0]   beatCnt;
  logic [3:0]   gapCnt;
  logic         armed;
  logic [1:0]   channelNext;
  logic         accept;

  // armed keeps topReady low until the first edge after reset release
  assign topIf.topReady = armed && (state == IDLE);
  assign accept         = topIf.topValid && topIf.topReady;
  assign busy           = (state != IDLE);
  assign stateDbg       = state;

  // The channel value is computed one cycle ahead so topChannel itself is a plain flop.
  always_comb begin
    stateNext   = state;
    channelNext = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext   = SEND;
          channelNext = {1'b1, topIf.top[0]};
        end
      end
      SEND: begin
        if (beatCnt == 7'd127) begin
          stateNext   = PARITY;
          channelNext = {1'b1, parityBit};
        end else begin
          channelNext = {1'b1, shiftReg[1]};
        end
      end
      PARITY: stateNext = GAP;
      GAP: begin
        if (gapCnt == GAP_LAST) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      topChannel <= 2'b00;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      beatCnt    <= '0;
      gapCnt     <= '0;
      framesSent <= '0;
      armed      <= 1'b0;
    end else begin
      state      <= stateNext;
      topChannel <= channelNext;
      armed      <= 1'b1;
      if (accept) begin
        shiftReg  <= topIf.top;
        parityBit <= ^topIf.top;
        beatCnt   <= '0;
      end else if (state == SEND) begin
        shiftReg <= shiftReg >> 1;
        beatCnt  <= beatCnt + 7'd1;
      end
      if (state == PARITY) begin
        gapCnt     <= '0;
        framesSent <= framesSent + COUNT_WIDTH'(1);
      end else if (state == GAP) begin
        gapCnt <= gapCnt + 4'd1;
      end
    end
  end

endmodule
